// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the 8-to-3 priority encoder family.
// The request-vector width, the code width, and the index/one-hot helper functions live here.
package prio_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef struct packed {
        logic              found;
        logic [CODE_W-1:0] idx;
    } prio_res_t;

    function automatic logic [N_REQ-1:0] onehot3(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] v;
        v       = {N_REQ{1'b0}};
        v[code] = 1'b1;
        return v;
    endfunction

    // Later loop iterations overwrite earlier ones, so the last matching bit scanned wins.
    function automatic prio_res_t prio_idx(input logic [N_REQ-1:0] vec, input logic high_first);
        prio_res_t r;
        r.found = |vec;
        r.idx   = {CODE_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (high_first) begin
                if (vec[i]) r.idx = CODE_W'(i);
            end else begin
                if (vec[N_REQ-1-i]) r.idx = CODE_W'(N_REQ-1-i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder.
// Produces the index of the highest-priority set bit and a flag that says whether any bit is set.
module prio_enc8
    import prio_enc_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [N_REQ-1:0]  vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              valid_o
);

    prio_res_t res_s;

    // Select the winning bit of the input vector.
    always_comb begin
        res_s = prio_idx(vec_i, HIGH_FIRST);
    end

    assign idx_o   = res_s.idx;
    assign valid_o = res_s.found;

endmodule

// File: rtl/prio_enc8x3_irq.sv
// Registered 8-to-3 priority encoder with sticky request capture and a valid/ready output.
// Accepting a code clears the matching pending bit.
module prio_enc8x3_irq
    import prio_enc_pkg::*;
#(
    parameter bit EDGE_MODE  = 1'b0,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    input  logic [N_REQ-1:0]  mask,
    output logic [CODE_W-1:0] code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_REQ-1:0]  pending,
    output logic              any_pending
);

    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  req_prev_q;
    logic [CODE_W-1:0] code_q, code_d;
    logic              out_valid_q, out_valid_d;

    logic [N_REQ-1:0]  set_s, clr_s, cand_s;
    logic              ack_s;
    logic [CODE_W-1:0] win_idx_s;
    logic              win_valid_s;

    prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_win (
        .vec_i   (cand_s),
        .idx_o   (win_idx_s),
        .valid_o (win_valid_s)
    );

    // Compute the request capture, the acknowledge clear, the pending update and the next output.
    always_comb begin
        set_s       = req_in;
        clr_s       = {N_REQ{1'b0}};
        code_d      = code_q;
        out_valid_d = out_valid_q;

        if (EDGE_MODE) begin
            set_s = req_in & ~req_prev_q;
        end else begin
            set_s = req_in;
        end

        ack_s = out_valid_q & out_ready;
        if (ack_s) begin
            clr_s = onehot3(code_q);
        end else begin
            clr_s = {N_REQ{1'b0}};
        end

        // The set term is ORed in last, so a bit that is set and cleared in the same cycle stays pending.
        pending_d = (pending_q & ~clr_s) | set_s;
        cand_s    = pending_d & ~mask;

        // A stalled grant stays frozen; it is never preempted or retracted.
        if (!out_valid_q || ack_s) begin
            out_valid_d = win_valid_s;
            if (win_valid_s) begin
                code_d = win_idx_s;
            end else begin
                code_d = code_q;
            end
        end else begin
            out_valid_d = out_valid_q;
            code_d      = code_q;
        end
    end

    // Register the pending bits, the edge-detect history and the output code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= {N_REQ{1'b0}};
            req_prev_q  <= {N_REQ{1'b0}};
            code_q      <= {CODE_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            req_prev_q  <= req_in;
            code_q      <= code_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign code        = code_q;
    assign out_valid   = out_valid_q;
    assign pending     = pending_q;
    assign any_pending = |(pending_q & ~mask);

endmodule
